// File: rtl/txgen_pkg.sv
// txgen_pkg: shared types and constants for the txgen frame generator.
//   state_e     - frame FSM states
//   CMD_*       - command bytes with special handling
//   CRC_*       - CRC-16/MODBUS parameters (reflected polynomial, init value)
//   CRC_BYTES   - number of CRC bytes appended (0 when TXGEN_CRC_EN is undefined)
//   frame_len() - LEN field value: CMD byte + optional 4-byte payload + CRC bytes
package txgen_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_TX   = 2'd3
    } state_e;

    localparam logic [7:0]  CMD_READ = 8'h03;
    localparam logic [7:0]  CMD_ERR  = 8'hEE;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

`ifdef TXGEN_CRC_EN
    localparam int unsigned CRC_BYTES = 2;
`else
    localparam int unsigned CRC_BYTES = 0;
`endif

    function automatic logic [15:0] frame_len(input logic has_payload);
        frame_len = 16'(32'd1 + CRC_BYTES + (has_payload ? 32'd4 : 32'd0));
    endfunction

endpackage

// File: rtl/txgen_crc.sv
// crc16_byte: combinational one-byte step of CRC-16/MODBUS (reflected, LSB first).
//   crc_in  [15:0] - running CRC before this byte
//   data_in [7:0]  - byte to fold in
//   crc_out [15:0] - running CRC after this byte
module crc16_byte
    import txgen_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_work;

    always_comb begin
        crc_work = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (crc_work[0]) begin
                crc_work = (crc_work >> 1) ^ CRC_POLY;
            end else begin
                crc_work = crc_work >> 1;
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/txgen.sv
// txgen: builds and transmits reply frames byte by byte to a UART transmitter.
// Frame: NODE_ID hi, NODE_ID lo, LEN hi, LEN lo, CMD, [4-byte sensor payload],
//        [CRC lo, CRC hi]. Payload only for CMD_READ; CRC only with TXGEN_CRC_EN.
// Ports:
//   sys_clk, sys_rst      - clock, asynchronous active-high reset
//   ret_cmd/ret_cmd_flg   - request command and its one-cycle strobe
//   sen_data/sen_data_flg - sensor word and its one-cycle strobe (used in WAIT_DATA only)
//   tx_busy               - transmitter busy
//   tx_data/tx_flag       - byte out and its one-cycle strobe
//   busy                  - FSM not idle
//   drop                  - one-cycle pulse when a request is discarded
// Handshake: strobes are valid-only (no ready). A byte is offered with tx_flag for
// one cycle; the transmitter then owns it until tx_busy falls. The cycle straight
// after tx_flag ignores tx_busy so the transmitter has time to raise it.
// Build option: define TXGEN_CRC_EN to compute and append the CRC.
module txgen
    import txgen_pkg::*;
#(
    parameter logic [15:0] NODE_ID = 16'h0001,
    parameter logic [23:0] TIMEOUT = 24'd100000
)(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  ret_cmd,
    input  logic        ret_cmd_flg,
    input  logic [31:0] sen_data,
    input  logic        sen_data_flg,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_flag,
    output logic        busy,
    output logic        drop
);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        wt_first_q, wt_first_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_cmd_q, pend_cmd_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_flag_q, tx_flag_d;
    logic        drop_q, drop_d;

    logic        has_payload;
    logic [15:0] len;
    logic [3:0]  last_idx;
    logic [3:0]  crc_idx;
    logic [7:0]  cur_byte;
    logic [7:0]  start_cmd;

`ifdef TXGEN_CRC_EN
    logic [15:0] crc_q, crc_d, crc_next;

    crc16_byte u_crc (
        .crc_in  (crc_q),
        .data_in (cur_byte),
        .crc_out (crc_next)
    );
`endif

    // After a timeout cmd_q holds CMD_ERR, so the payload disappears with it.
    assign has_payload = (cmd_q == CMD_READ);
    assign len         = frame_len(has_payload);
    assign last_idx    = 4'(len + 16'd3);
    // First byte index past the payload: CRC bytes when enabled, else end of frame.
    assign crc_idx     = has_payload ? 4'd9 : 4'd5;
    // A waiting pending entry is served before a request arriving in the same cycle.
    assign start_cmd   = pend_vld_q ? pend_cmd_q : ret_cmd;

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            4'd0: cur_byte = NODE_ID[15:8];
            4'd1: cur_byte = NODE_ID[7:0];
            4'd2: cur_byte = len[15:8];
            4'd3: cur_byte = len[7:0];
            4'd4: cur_byte = cmd_q;
            default: begin
                if (idx_q < crc_idx) begin
                    case (idx_q)
                        4'd5:    cur_byte = data_q[31:24];
                        4'd6:    cur_byte = data_q[23:16];
                        4'd7:    cur_byte = data_q[15:8];
                        default: cur_byte = data_q[7:0];
                    endcase
                end
`ifdef TXGEN_CRC_EN
                else if (idx_q == crc_idx) begin
                    cur_byte = crc_q[7:0];
                end else begin
                    cur_byte = crc_q[15:8];
                end
`endif
            end
        endcase
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wt_first_d = wt_first_q;
        pend_vld_d = pend_vld_q;
        pend_cmd_d = pend_cmd_q;
`ifdef TXGEN_CRC_EN
        crc_d      = crc_q;
`endif

        // Requests arriving mid-frame go to the single-entry buffer if it is free.
        if (ret_cmd_flg && (state_q != S_IDLE) && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_cmd_d = ret_cmd;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_vld_q || ret_cmd_flg) begin
                    cmd_d = start_cmd;
                    idx_d = 4'd0;
                    cnt_d = 24'd0;
`ifdef TXGEN_CRC_EN
                    crc_d = CRC_INIT;
`endif
                    if (pend_vld_q) begin
                        // The freed slot takes a request arriving in this same cycle.
                        pend_vld_d = ret_cmd_flg;
                        pend_cmd_d = ret_cmd;
                    end
                    state_d = (start_cmd == CMD_READ) ? S_WAIT_DATA : S_SEND;
                end
            end
            S_WAIT_DATA: begin
                // Data is checked first so it wins over a simultaneous timeout.
                if (sen_data_flg) begin
                    data_d  = sen_data;
                    state_d = S_SEND;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    cmd_d   = CMD_ERR;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_SEND: begin
`ifdef TXGEN_CRC_EN
                if (idx_q < crc_idx) begin
                    crc_d = crc_next;
                end
`endif
                idx_d      = idx_q + 4'd1;
                wt_first_d = 1'b1;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (wt_first_q) begin
                    wt_first_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = (idx_q > last_idx) ? S_IDLE : S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        tx_flag_d = (state_q == S_SEND);
        tx_data_d = (state_q == S_SEND) ? cur_byte : tx_data_q;
        drop_d    = ret_cmd_flg && (state_q != S_IDLE) && pend_vld_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= 8'h00;
            data_q     <= 32'h0;
            cnt_q      <= 24'd0;
            idx_q      <= 4'd0;
            wt_first_q <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_cmd_q <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_flag_q  <= 1'b0;
            drop_q     <= 1'b0;
`ifdef TXGEN_CRC_EN
            crc_q      <= CRC_INIT;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wt_first_q <= wt_first_d;
            pend_vld_q <= pend_vld_d;
            pend_cmd_q <= pend_cmd_d;
            tx_data_q  <= tx_data_d;
            tx_flag_q  <= tx_flag_d;
            drop_q     <= drop_d;
`ifdef TXGEN_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign tx_data = tx_data_q;
    assign tx_flag = tx_flag_q;
    assign drop    = drop_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_txgen.sv
// tb_txgen: directed bench for txgen. Expected frames are built from the frame
// rules and queued; every tx_flag byte is popped and compared.
module tb_txgen;

    localparam logic [15:0] NODE = 16'h0001;
`ifdef TXGEN_CRC_EN
    localparam int CRC_N = 2;
`else
    localparam int CRC_N = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  ret_cmd = 8'h00;
    logic        ret_cmd_flg = 1'b0;
    logic [31:0] sen_data = 32'h0;
    logic        sen_data_flg = 1'b0;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_flag;
    logic        busy;
    logic        drop;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int flag_cnt = 0;
    int drop_cnt = 0;
    int last_flag_cyc = -100;
    int busy_len = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frm[$];

    txgen #(.NODE_ID(NODE), .TIMEOUT(24'd100)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .ret_cmd      (ret_cmd),
        .ret_cmd_flg  (ret_cmd_flg),
        .sen_data     (sen_data),
        .sen_data_flg (sen_data_flg),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .tx_flag      (tx_flag),
        .busy         (busy),
        .drop         (drop)
    );

    // ---------------- clock / watchdog ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model ----------------
    function automatic logic [15:0] crc_of(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic void make_frame(input logic [7:0] cmd, input logic [31:0] data);
        logic [15:0] c;
        int len;
        len = 1 + CRC_N + ((cmd == 8'h03) ? 4 : 0);
        frm.delete();
        frm.push_back(NODE[15:8]);
        frm.push_back(NODE[7:0]);
        frm.push_back(8'(len >> 8));
        frm.push_back(8'(len));
        frm.push_back(cmd);
        if (cmd == 8'h03) begin
            for (int k = 3; k >= 0; k--) frm.push_back(data[8*k +: 8]);
        end
        if (CRC_N == 2) begin
            c = crc_of(frm);
            frm.push_back(c[7:0]);
            frm.push_back(c[15:8]);
        end
    endfunction

    function automatic void push_frame(input logic [7:0] cmd, input logic [31:0] data);
        make_frame(cmd, data);
        foreach (frm[i]) exp_q.push_back(frm[i]);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge sys_clk) begin
        cyc++;
        if (drop) drop_cnt++;
        if (!sys_rst && tx_flag) begin
            flag_cnt++;
            check("flag_gap", 32'(cyc - last_flag_cyc >= 2), 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
            end else begin
                check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            last_flag_cyc = cyc;
        end
    end

    // ---------------- transmitter model ----------------
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (tx_flag && busy_len > 0) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge sys_clk);
                tx_busy = 1'b0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [7:0] c);
        ret_cmd = c;
        ret_cmd_flg = 1'b1;
        @(negedge sys_clk);
        ret_cmd_flg = 1'b0;
        ret_cmd = 8'h00;
    endtask

    task automatic send_data(input logic [31:0] d);
        sen_data = d;
        sen_data_flg = 1'b1;
        @(negedge sys_clk);
        sen_data_flg = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < max) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, "_done"}, 32'(n < max), 32'd1);
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic wait_flags(input string name, input int count, input int max);
        int n;
        int k;
        n = 0;
        k = 0;
        while (k < count && n < max) begin
            @(negedge sys_clk);
            n++;
            if (tx_flag) k++;
        end
        check({name, "_flags_seen"}, 32'(k), 32'(count));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] ascii_q[$];
        int fc0;
        int d0;
        int n;

        repeat (3) @(negedge sys_clk);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_flag", 32'(tx_flag), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // model pins against hand-known values
        ascii_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("pin_crc_check", 32'(crc_of(ascii_q)), 32'h4B37);
        make_frame(8'h01, 32'h0);
        check("pin_len01", 32'(frm.size()), (CRC_N == 2) ? 32'd7 : 32'd5);
        check("pin_len01_lo", 32'(frm[3]), (CRC_N == 2) ? 32'h03 : 32'h01);
        check("pin_cmd01", 32'(frm[4]), 32'h01);
        make_frame(8'h03, 32'h11223344);
        check("pin_len03", 32'(frm.size()), (CRC_N == 2) ? 32'd11 : 32'd9);
        check("pin_len03_lo", 32'(frm[3]), (CRC_N == 2) ? 32'h07 : 32'h05);
        check("pin_pay0", 32'(frm[5]), 32'h11);
        check("pin_pay3", 32'(frm[8]), 32'h44);

        // plain command, slow transmitter
        busy_len = 10;
        push_frame(8'h01, 32'h0);
        fc0 = flag_cnt;
        send_cmd(8'h01);
        wait_done("cmd01", 500);
        check("cmd01_nflags", 32'(flag_cnt - fc0), 32'(5 + CRC_N));

        // read command; stray sensor strobe in IDLE must be ignored
        busy_len = 3;
        send_data(32'hDEADBEEF);
        push_frame(8'h03, 32'h11223344);
        send_cmd(8'h03);
        repeat (49) @(negedge sys_clk);
        send_data(32'h11223344);
        wait_done("read", 500);

        // read command with no sensor data: timeout
        busy_len = 0;
        push_frame(8'hEE, 32'h0);
        send_cmd(8'h03);
        n = 0;
        while (!tx_flag && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        check("timeout_min_wait", 32'(n >= 100), 32'd1);
        check("timeout_max_wait", 32'(n <= 110), 32'd1);
        wait_done("timeout", 300);

        // sensor strobe in the same cycle as the timeout: data wins
        push_frame(8'h03, 32'h5AA5C33C);
        send_cmd(8'h03);
        repeat (99) @(negedge sys_clk);
        send_data(32'h5AA5C33C);
        wait_done("data_wins", 300);

        // three requests during one frame: second pending, third dropped
        busy_len = 4;
        d0 = drop_cnt;
        push_frame(8'h01, 32'h0);
        push_frame(8'h02, 32'h0);
        send_cmd(8'h01);
        repeat (5) @(negedge sys_clk);
        send_cmd(8'h02);
        repeat (5) @(negedge sys_clk);
        send_cmd(8'h04);
        wait_done("pending", 800);
        check("pending_drops", 32'(drop_cnt - d0), 32'd1);

        // request in the cycle of the final WAIT_TX exit: buffered, not dropped
        busy_len = 0;
        d0 = drop_cnt;
        push_frame(8'h01, 32'h0);
        push_frame(8'h06, 32'h0);
        send_cmd(8'h01);
        wait_flags("lastexit", 5 + CRC_N, 200);
        @(negedge sys_clk);
        send_cmd(8'h06);
        wait_done("lastexit", 300);
        check("lastexit_drops", 32'(drop_cnt - d0), 32'd0);

        // reset during payload byte 2, then a clean frame
        busy_len = 2;
        push_frame(8'h03, 32'hCAFEF00D);
        send_cmd(8'h03);
        repeat (3) @(negedge sys_clk);
        send_data(32'hCAFEF00D);
        wait_flags("midrst", 7, 200);
        #2;
        sys_rst = 1'b1;
        #1;
        check("midrst_tx_flag", 32'(tx_flag), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_tx_data", 32'(tx_data), 32'h0);
        check("midrst_drop", 32'(drop), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        check("midrst_held_busy", 32'(busy), 32'h0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("midrst_no_resume", 32'(busy), 32'h0);
        push_frame(8'h03, 32'h01020304);
        send_cmd(8'h03);
        repeat (10) @(negedge sys_clk);
        send_data(32'h01020304);
        wait_done("after_rst", 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
